// File: rtl/qea_host_seq.sv
// qea_host_seq: autonomous host sequencer for the QEA core.
// On a go pulse it loads the context RAM and initialises the state RAM
// to |0...0>. It then starts the core and counts cycles until completion,
// and finally streams every state row out over a valid/ready interface.
module qea_host_seq #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int RD_LATENCY              = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_word,
  output logic                                 o_qea_ctx_en,
  output logic                                 o_qea_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
  output logic                                 o_qea_state_ena,
  output logic                                 o_qea_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
  output logic                                 o_st_valid,
  input  logic                                 i_st_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_st_data,
  output logic [STATE_ADDR_WIDTH-1:0]          o_st_addr,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [31:0]                          o_cycles
);

  localparam int ROW_W = PE_NUM*STATE_DATA_WIDTH;
  localparam int LAT_W = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY+1);
  localparam int CAW   = GATE_CONTEXT_ADDR_WIDTH;
  localparam int SAW   = STATE_ADDR_WIDTH;

  // Amplitude 1.0 in the real part of the top PE lane; everything else zero.
  localparam logic [DATA_WIDTH-1:0] ONE_Q    = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  localparam logic [ROW_W-1:0]      ROW0_VAL = {ONE_Q, {(ROW_W-DATA_WIDTH){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, LOAD_CTX, INIT_ST, START, WAIT_CPL, RD_ISSUE, RD_WAIT, RD_HOLD, DONE
  } state_t;

  state_t                 state_reg, state_next;
  logic [MAX_QBIT_WIDTH-1:0] qbit_reg, qbit_next;
  logic [CAW:0]           ins_last_reg, ins_last_next;
  logic [SAW-1:0]         rows_last_reg, rows_last_next;
  logic [CAW-1:0]         ctx_cnt_reg, ctx_cnt_next;
  logic [SAW-1:0]         row_reg, row_next;
  logic [LAT_W-1:0]       lat_reg, lat_next;
  logic [31:0]            cycles_reg, cycles_next;
  logic                   ctx_ready_reg, ctx_ready_next;
  logic                   ctx_en_reg, ctx_en_next;
  logic [CAW-1:0]         ctx_addr_reg, ctx_addr_next;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_reg, ctx_data_next;
  logic                   st_ena_reg, st_ena_next;
  logic                   st_wea_reg, st_wea_next;
  logic [SAW-1:0]         st_addr_reg, st_addr_next;
  logic [ROW_W-1:0]       st_dina_reg, st_dina_next;
  logic                   start_reg, start_next;
  logic                   res_valid_reg, res_valid_next;
  logic [ROW_W-1:0]       res_data_reg, res_data_next;
  logic [SAW-1:0]         res_addr_reg, res_addr_next;
  logic                   done_reg, done_next;
  logic                   err_reg, err_next;

  // Run-request validation and row count derived from the requested qubit count.
  logic [MAX_QBIT_WIDTH-1:0] row_shift;
  logic [SAW:0]              rows_full;
  logic                      go_ok;
  assign row_shift = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  assign rows_full = (SAW+1)'(1) << row_shift;
  assign go_ok     = (i_qbit_num >= MAX_QBIT_WIDTH'(PE_NUM_WIDTH))
                  && (row_shift <= MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH))
                  && (i_ins_num != '0);

  // State and registered-output update; reset clears everything so an aborted run emits nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      qbit_reg      <= '0;
      ins_last_reg  <= '0;
      rows_last_reg <= '0;
      ctx_cnt_reg   <= '0;
      row_reg       <= '0;
      lat_reg       <= '0;
      cycles_reg    <= '0;
      ctx_ready_reg <= 1'b0;
      ctx_en_reg    <= 1'b0;
      ctx_addr_reg  <= '0;
      ctx_data_reg  <= '0;
      st_ena_reg    <= 1'b0;
      st_wea_reg    <= 1'b0;
      st_addr_reg   <= '0;
      st_dina_reg   <= '0;
      start_reg     <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_addr_reg  <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      qbit_reg      <= qbit_next;
      ins_last_reg  <= ins_last_next;
      rows_last_reg <= rows_last_next;
      ctx_cnt_reg   <= ctx_cnt_next;
      row_reg       <= row_next;
      lat_reg       <= lat_next;
      cycles_reg    <= cycles_next;
      ctx_ready_reg <= ctx_ready_next;
      ctx_en_reg    <= ctx_en_next;
      ctx_addr_reg  <= ctx_addr_next;
      ctx_data_reg  <= ctx_data_next;
      st_ena_reg    <= st_ena_next;
      st_wea_reg    <= st_wea_next;
      st_addr_reg   <= st_addr_next;
      st_dina_reg   <= st_dina_next;
      start_reg     <= start_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
      res_addr_reg  <= res_addr_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  // Next-state logic and next values of every registered output (pulses default low).
  always_comb begin
    state_next     = state_reg;
    qbit_next      = qbit_reg;
    ins_last_next  = ins_last_reg;
    rows_last_next = rows_last_reg;
    ctx_cnt_next   = ctx_cnt_reg;
    row_next       = row_reg;
    lat_next       = lat_reg;
    cycles_next    = cycles_reg;
    ctx_ready_next = 1'b0;
    ctx_en_next    = 1'b0;
    ctx_addr_next  = ctx_addr_reg;
    ctx_data_next  = ctx_data_reg;
    st_ena_next    = 1'b0;
    st_wea_next    = 1'b0;
    st_addr_next   = st_addr_reg;
    st_dina_next   = st_dina_reg;
    start_next     = 1'b0;
    res_valid_next = 1'b0;
    res_data_next  = res_data_reg;
    res_addr_next  = res_addr_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_go) begin
          if (go_ok) begin
            state_next     = LOAD_CTX;
            qbit_next      = i_qbit_num;
            ins_last_next  = i_ins_num - 1'b1;
            rows_last_next = SAW'(rows_full - 1'b1);
            ctx_cnt_next   = '0;
            cycles_next    = '0;
            ctx_ready_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      LOAD_CTX: begin
        ctx_ready_next = 1'b1;
        if (i_ctx_valid && ctx_ready_reg) begin
          ctx_en_next   = 1'b1;
          ctx_addr_next = ctx_cnt_reg;
          ctx_data_next = i_ctx_word;
          ctx_cnt_next  = ctx_cnt_reg + 1'b1;
          if ({1'b0, ctx_cnt_reg} == ins_last_reg) begin
            ctx_ready_next = 1'b0;
            row_next       = '0;
            state_next     = INIT_ST;
          end
        end
      end
      INIT_ST: begin
        st_ena_next  = 1'b1;
        st_wea_next  = 1'b1;
        st_addr_next = row_reg;
        st_dina_next = (row_reg == '0) ? ROW0_VAL : '0;
        if (row_reg == rows_last_reg) begin
          state_next = START;
        end else begin
          row_next = row_reg + 1'b1;
        end
      end
      START: begin
        start_next = 1'b1;
        state_next = WAIT_CPL;
      end
      WAIT_CPL: begin
        if (i_qea_complete) begin
          row_next   = '0;
          state_next = RD_ISSUE;
        end else if (cycles_reg != '1) begin
          cycles_next = cycles_reg + 1'b1;
        end
      end
      RD_ISSUE: begin
        st_ena_next  = 1'b1;
        st_addr_next = row_reg;
        lat_next     = '0;
        state_next   = RD_WAIT;
      end
      RD_WAIT: begin
        // lat_reg counts cycles since the read enable became visible to the RAM.
        if (lat_reg == LAT_W'(RD_LATENCY)) begin
          res_data_next  = i_qea_state_dout;
          res_addr_next  = row_reg;
          res_valid_next = 1'b1;
          state_next     = RD_HOLD;
        end else begin
          lat_next = lat_reg + 1'b1;
        end
      end
      RD_HOLD: begin
        res_valid_next = 1'b1;
        if (i_st_ready) begin
          res_valid_next = 1'b0;
          if (row_reg == rows_last_reg) begin
            state_next = DONE;
          end else begin
            row_next   = row_reg + 1'b1;
            state_next = RD_ISSUE;
          end
        end
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_ctx_ready       = ctx_ready_reg;
  assign o_qea_ctx_en      = ctx_en_reg;
  assign o_qea_ctx_wea     = ctx_en_reg;
  assign o_qea_ctx_addr    = ctx_addr_reg;
  assign o_qea_ctx_data    = ctx_data_reg;
  assign o_qea_state_ena   = st_ena_reg;
  assign o_qea_state_wea   = st_wea_reg;
  assign o_qea_state_addra = st_addr_reg;
  assign o_qea_state_dina  = st_dina_reg;
  assign o_qea_start       = start_reg;
  assign o_qea_qbit_num    = qbit_reg;
  assign o_st_valid        = res_valid_reg;
  assign o_st_data         = res_data_reg;
  assign o_st_addr         = res_addr_reg;
  assign o_busy            = (state_reg != IDLE);
  assign o_done            = done_reg;
  assign o_err             = err_reg;
  assign o_cycles          = cycles_reg;

endmodule

// File: tb/tb_qea_host_seq.sv
// tb_qea_host_seq: randomized self-checking bench for qea_host_seq.
// The environment process models the context source, the QEA state RAM and
// completion behaviour, and the result sink. It records every transaction.
// Scenario tasks compare the records with expectations built from the run parameters.
module tb_qea_host_seq;
  localparam int ROW_W = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               go = 1'b0;
  logic [5:0]         qbit_num = '0;
  logic [16:0]        ins_num = '0;
  logic               ctx_valid = 1'b0;
  logic               ctx_ready;
  logic [63:0]        ctx_word = '0;
  logic               qea_ctx_en, qea_ctx_wea;
  logic [15:0]        qea_ctx_addr;
  logic [63:0]        qea_ctx_data;
  logic               qea_state_ena, qea_state_wea;
  logic [15:0]        qea_state_addra;
  logic [ROW_W-1:0]   qea_state_dina;
  logic               qea_start;
  logic [5:0]         qea_qbit_num;
  logic               qea_complete = 1'b0;
  logic [ROW_W-1:0]   qea_state_dout = '0;
  logic               st_valid;
  logic               st_ready = 1'b0;
  logic [ROW_W-1:0]   st_data;
  logic [15:0]        st_addr;
  logic               busy, done, err;
  logic [31:0]        cycles;

  qea_host_seq dut (
    .clk(clk), .rst_n(rst_n), .i_go(go), .i_qbit_num(qbit_num), .i_ins_num(ins_num),
    .i_ctx_valid(ctx_valid), .o_ctx_ready(ctx_ready), .i_ctx_word(ctx_word),
    .o_qea_ctx_en(qea_ctx_en), .o_qea_ctx_wea(qea_ctx_wea), .o_qea_ctx_addr(qea_ctx_addr),
    .o_qea_ctx_data(qea_ctx_data), .o_qea_state_ena(qea_state_ena), .o_qea_state_wea(qea_state_wea),
    .o_qea_state_addra(qea_state_addra), .o_qea_state_dina(qea_state_dina), .o_qea_start(qea_start),
    .o_qea_qbit_num(qea_qbit_num), .i_qea_complete(qea_complete), .i_qea_state_dout(qea_state_dout),
    .o_st_valid(st_valid), .i_st_ready(st_ready), .o_st_data(st_data), .o_st_addr(st_addr),
    .o_busy(busy), .o_done(done), .o_err(err), .o_cycles(cycles)
  );

  int n_assert = 0;
  int n_fail = 0;

  // Parameters written by the scenario tasks, read by the environment.
  logic [63:0] src_words [0:511];
  int src_n = 0;
  bit src_rand = 0;
  int gap_at = -1, gap_len = 0;
  int ready_mode = 0;
  int cpl_delay = 1;
  int fill_rows = 0;
  int clr_req = 0;

  // State owned by the environment process.
  int clr_ack = 0, cyc = 0, sent = 0, gap_left = 0, cd = 0;
  logic [15:0]      ctx_addr_q [$];
  logic [63:0]      ctx_data_q [$];
  logic [15:0]      init_addr_q [$];
  logic [ROW_W-1:0] init_data_q [$];
  logic [15:0]      res_addr_q [$];
  logic [ROW_W-1:0] res_data_q [$];
  int ctx_first = 0, ctx_last = 0;
  int start_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, stab_err = 0, wr_cnt = 0;
  logic [ROW_W-1:0] mem [0:255];
  logic [ROW_W-1:0] exp_mem [0:255];
  bit rd_pend = 0;
  logic [ROW_W-1:0] rd_data = '0;
  bit hold_prev = 0;
  logic [ROW_W-1:0] hold_data = '0;
  logic [15:0] hold_addr = '0;

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Environment: source, RAM model, completion model, sink, and transaction monitor.
  always @(negedge clk) begin
    cyc++;
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      ctx_addr_q.delete(); ctx_data_q.delete();
      init_addr_q.delete(); init_data_q.delete();
      res_addr_q.delete(); res_data_q.delete();
      start_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; stab_err = 0; wr_cnt = 0;
      sent = 0; gap_left = gap_len; hold_prev = 0;
    end
    if (!rst_n) begin
      cd = 0; qea_complete = 1'b0; rd_pend = 0; st_ready = 1'b0; ctx_valid = 1'b0; hold_prev = 0;
    end else begin
      // State RAM: one-cycle registered read, write-through of the DUT's writes.
      qea_state_dout = rd_pend ? rd_data : rand_row();
      rd_pend = 0;
      if (qea_state_ena) begin
        if (qea_state_wea) begin
          mem[qea_state_addra[7:0]] = qea_state_dina;
          init_addr_q.push_back(qea_state_addra);
          init_data_q.push_back(qea_state_dina);
          wr_cnt++;
        end else begin
          rd_pend = 1;
          rd_data = mem[qea_state_addra[7:0]];
        end
      end
      if (qea_ctx_en && qea_ctx_wea) begin
        ctx_addr_q.push_back(qea_ctx_addr);
        ctx_data_q.push_back(qea_ctx_data);
        if (ctx_addr_q.size() == 1) ctx_first = cyc;
        ctx_last = cyc;
        wr_cnt++;
      end
      if (qea_start) start_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (busy) busy_cnt++;
      // Core model: after cpl_delay cycles it has computed fresh amplitudes.
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          qea_complete = 1'b1;
          for (int i = 0; i < fill_rows; i++) begin
            mem[i] = rand_row();
            exp_mem[i] = mem[i];
          end
        end
      end
      if (qea_start) begin
        cd = cpl_delay;
        qea_complete = 1'b0;
      end
      // Result sink with stability check on stalled rows.
      if (hold_prev && (!st_valid || st_data !== hold_data || st_addr !== hold_addr)) stab_err++;
      case (ready_mode)
        0: st_ready = 1'b1;
        1: st_ready = (cyc % 3 == 0);
        default: st_ready = 1'($urandom_range(0, 1));
      endcase
      hold_prev = st_valid && !st_ready;
      hold_data = st_data;
      hold_addr = st_addr;
      if (st_valid && st_ready) begin
        res_addr_q.push_back(st_addr);
        res_data_q.push_back(st_data);
      end
      // Context source.
      if (gap_left > 0 && sent == gap_at) begin
        ctx_valid = 1'b0;
        gap_left--;
      end else begin
        ctx_valid = (sent < src_n) && (!src_rand || $urandom_range(0, 2) != 0);
      end
      ctx_word = (sent < src_n) ? src_words[sent] : '0;
      if (ctx_valid && ctx_ready) sent++;
    end
  end

  task automatic do_run(input int qb, input int ins, input int dly, input int rmode,
                        input int gat, input int glen, input bit srand, input bit bgo);
    int rows;
    int bad;
    logic [ROW_W-1:0] exp_row;
    rows = 1 << (qb - 2);
    for (int i = 0; i < ins; i++) src_words[i] = {$urandom, $urandom};
    src_n = ins; fill_rows = rows; cpl_delay = dly; ready_mode = rmode;
    gap_at = gat; gap_len = glen; src_rand = srand;
    clr_req++;
    @(negedge clk);
    qbit_num = 6'(qb); ins_num = 17'(ins); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_go: got %b want 1", busy); end
    if (bgo) begin
      repeat (3) @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
    n_assert++;
    if (done_cnt == 0) begin n_fail++; $display("FAIL run_timeout: done never seen (qb=%0d ins=%0d)", qb, ins); end
    repeat (3) @(negedge clk);

    n_assert++;
    if (ctx_addr_q.size() != ins) begin n_fail++; $display("FAIL ctx_count: got %0d want %0d", ctx_addr_q.size(), ins); end
    bad = -1;
    for (int k = 0; k < ctx_addr_q.size() && k < ins; k++)
      if (bad < 0 && (ctx_addr_q[k] !== 16'(k) || ctx_data_q[k] !== src_words[k])) bad = k;
    n_assert++;
    if (bad >= 0) begin n_fail++; $display("FAIL ctx_stream: idx %0d got addr %0d data %h want addr %0d data %h", bad, ctx_addr_q[bad], ctx_data_q[bad], bad, src_words[bad]); end
    if (!srand) begin
      n_assert++;
      if (ctx_last - ctx_first + 1 != ins + glen) begin n_fail++; $display("FAIL ctx_span: got %0d cycles want %0d", ctx_last - ctx_first + 1, ins + glen); end
    end
    n_assert++;
    if (init_addr_q.size() != rows) begin n_fail++; $display("FAIL init_count: got %0d want %0d", init_addr_q.size(), rows); end
    bad = -1;
    for (int k = 0; k < init_addr_q.size() && k < rows; k++) begin
      exp_row = '0;
      if (k == 0) exp_row[ROW_W-1 -: 32] = 32'h4000_0000;
      if (bad < 0 && (init_addr_q[k] !== 16'(k) || init_data_q[k] !== exp_row)) bad = k;
    end
    n_assert++;
    if (bad >= 0) begin n_fail++; $display("FAIL init_rows: row %0d got addr %0d data %h", bad, init_addr_q[bad], init_data_q[bad]); end
    n_assert++;
    if (start_cnt != 1) begin n_fail++; $display("FAIL start_pulses: got %0d want 1", start_cnt); end
    n_assert++;
    if (cycles !== 32'(dly)) begin n_fail++; $display("FAIL cycles: got %0d want %0d", cycles, dly); end
    n_assert++;
    if (res_addr_q.size() != rows) begin n_fail++; $display("FAIL result_count: got %0d want %0d", res_addr_q.size(), rows); end
    bad = -1;
    for (int k = 0; k < res_addr_q.size() && k < rows; k++)
      if (bad < 0 && (res_addr_q[k] !== 16'(k) || res_data_q[k] !== exp_mem[k])) bad = k;
    n_assert++;
    if (bad >= 0) begin n_fail++; $display("FAIL result_rows: row %0d got addr %0d data %h want %h", bad, res_addr_q[bad], res_data_q[bad], exp_mem[bad]); end
    n_assert++;
    if (stab_err != 0) begin n_fail++; $display("FAIL result_stable: got %0d changes want 0", stab_err); end
    n_assert++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
    n_assert++;
    if (err_cnt != 0) begin n_fail++; $display("FAIL err_during_run: got %0d want 0", err_cnt); end
    n_assert++;
    if (busy !== 1'b0 || qea_qbit_num !== 6'(qb)) begin n_fail++; $display("FAIL end_state: busy %b qbit %0d want 0 %0d", busy, qea_qbit_num, qb); end
    $display("run qb=%0d ins=%0d delay=%0d rows=%0d results=%0d cycles=%0d", qb, ins, dly, rows, res_addr_q.size(), cycles);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_assert++;
    if ({busy, done, err, st_valid, ctx_ready, qea_start, qea_ctx_en, qea_state_ena} !== 8'h00 || cycles !== 32'd0 || qea_qbit_num !== 6'd0) begin
      n_fail++; $display("FAIL reset_outputs: busy %b done %b err %b valid %b cycles %0d want all 0", busy, done, err, st_valid, cycles);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy %b want 0", busy); end
    $display("reset check done");
  endtask

  task automatic try_bad_go(input int qb, input int ins);
    src_n = 0;
    clr_req++;
    @(negedge clk);
    qbit_num = 6'(qb); ins_num = 17'(ins); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    n_assert++;
    if (err_cnt != 1) begin n_fail++; $display("FAIL err_pulse: qb=%0d ins=%0d got %0d want 1", qb, ins, err_cnt); end
    n_assert++;
    if (busy_cnt != 0 || wr_cnt != 0 || start_cnt != 0) begin
      n_fail++; $display("FAIL reject_quiet: busy cycles %0d writes %0d starts %0d want 0", busy_cnt, wr_cnt, start_cnt);
    end
    $display("rejected go qb=%0d ins=%0d err=%0d", qb, ins, err_cnt);
  endtask

  task automatic test_go_reject();
    try_bad_go(1, 10);
    try_bad_go(19, 10);
    try_bad_go(4, 0);
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 5; i++) src_words[i] = {$urandom, $urandom};
    src_n = 5; fill_rows = 4; cpl_delay = 200; ready_mode = 0; gap_at = -1; gap_len = 0; src_rand = 0;
    clr_req++;
    @(negedge clk);
    qbit_num = 6'd4; ins_num = 17'd5; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < 200 && start_cnt == 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({busy, done, err, st_valid, ctx_ready, qea_start, qea_ctx_en, qea_state_ena} !== 8'h00 || cycles !== 32'd0 || qea_qbit_num !== 6'd0) begin
      n_fail++; $display("FAIL midrun_reset_outputs: busy %b valid %b cycles %0d qbit %0d want all 0", busy, st_valid, cycles, qea_qbit_num);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr_req++;
    repeat (30) @(negedge clk);
    n_assert++;
    if (res_addr_q.size() != 0 || done_cnt != 0 || busy_cnt != 0) begin
      n_fail++; $display("FAIL no_results_after_reset: results %0d done %0d busy %0d want 0", res_addr_q.size(), done_cnt, busy_cnt);
    end
    $display("mid-run reset applied and released");
    do_run(4, 12, 17, 0, -1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    // Long context load, 100-cycle core, sink always ready.
    do_run(5, 411, 100, 0, -1, 0, 0, 0);
    // Sink ready every third cycle, plus a go while busy.
    do_run(5, 20, 7, 1, -1, 0, 0, 1);
    test_go_reject();
    test_reset_midrun();
    // Five-cycle gap in the context source after 12 words.
    do_run(4, 30, 10, 0, 12, 5, 0, 0);
    // Single-row, single-word boundary.
    do_run(2, 1, 1, 0, -1, 0, 0, 0);
    for (int t = 0; t < 4; t++)
      do_run($urandom_range(2, 6), $urandom_range(1, 40), $urandom_range(1, 40), 2, -1, 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
